// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped MSI cache controller.
package cache_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // MSI coherence state held per line
  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msiState_t;

  // Directory request opcodes as they appear on dirReqOp
  typedef enum logic [1:0] {
    OP_RD_MISS   = 2'd0,
    OP_WR_MISS   = 2'd1,
    OP_UPGRADE   = 2'd2,
    OP_WRITEBACK = 2'd3
  } dirOp_t;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB_REQ    = 2'd1,
    MISS_REQ  = 2'd2,
    WAIT_RESP = 2'd3
  } ctrlState_t;

endpackage

// File: rtl/cache_line_array.sv
// Line storage: tag, data and MSI state per line. One synchronous write
// port, one combinational lookup port for the processor side, and a
// combinational lookup plus clear port for directory invalidations.
// A write and an invalidation clear to the same line in the same cycle
// resolve in favour of the write (the write carries the newer grant).
module cache_line_array
  import cache_pkg::*;
#(
  parameter  int LINES = 4,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic [DATA_W-1:0] wrData,
  input  msiState_t         wrState,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [TAG_W-1:0]  rdTag,
  output logic [DATA_W-1:0] rdData,
  output msiState_t         rdState,
  input  logic [IDX_W-1:0]  invIdx,
  input  logic              invClr,
  output logic [TAG_W-1:0]  invTag,
  output logic [DATA_W-1:0] invData,
  output msiState_t         invState
);

  logic [LINES-1:0][TAG_W-1:0]  tagMem;
  logic [LINES-1:0][DATA_W-1:0] dataMem;
  logic [LINES-1:0][1:0]        stateMem;

  // Storage update: invalidation clear first, processor-side write last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tagMem   <= '0;
      dataMem  <= '0;
      stateMem <= '0;
    end else begin
      if (invClr) stateMem[invIdx] <= MSI_I;
      if (wrEn) begin
        tagMem[wrIdx]   <= wrTag;
        dataMem[wrIdx]  <= wrData;
        stateMem[wrIdx] <= wrState;
      end
    end
  end

  // Combinational lookups
  always_comb begin
    rdTag    = tagMem[rdIdx];
    rdData   = dataMem[rdIdx];
    rdState  = msiState_t'(stateMem[rdIdx]);
    invTag   = tagMem[invIdx];
    invData  = dataMem[invIdx];
    invState = msiState_t'(stateMem[invIdx]);
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped MSI cache controller between a processor port and a
// directory. Optional hit/miss counters are enabled with CACHE_STATS_EN.
//
// Directory request handshake: dirReqValid with dirReqOp/Addr/Data is held
// stable from the cycle it rises until the cycle dirReqReady is sampled
// high; the transfer happens on that clock edge and the FSM advances.
// A pending UPGRADE whose line is invalidated meanwhile needs no special
// handling: the reply always installs tag, dataP and M, which is exactly
// WR_MISS completion.
module cache_controller
  import cache_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValidP,
  input  logic              operationP,
  input  logic [ADDR_W-1:0] addressP,
  input  logic [DATA_W-1:0] dataP,
  output logic              stallP,
  output logic [DATA_W-1:0] readDataP,
  output logic              readValidP,
  output logic              dirReqValid,
  output logic [1:0]        dirReqOp,
  output logic [ADDR_W-1:0] dirReqAddr,
  output logic [DATA_W-1:0] dirReqData,
  input  logic              dirReqReady,
  input  logic              dirRespValid,
  input  logic [DATA_W-1:0] dirRespData,
  input  logic              invValid,
  input  logic [ADDR_W-1:0] invAddr,
  output logic              invAck,
  output logic [DATA_W-1:0] invData,
  output logic              invDirty,
  output ctrlState_t        dbgState
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  ctrlState_t state, nextState;

  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic [TAG_W-1:0]  rdTag, invTag;
  logic [DATA_W-1:0] rdData, invLineData;
  msiState_t         rdState, invState;
  logic              lineHit, invMatch, invClr;

  logic              wrEn;
  logic [IDX_W-1:0]  wrIdx;
  logic [TAG_W-1:0]  wrTag;
  logic [DATA_W-1:0] wrData;
  msiState_t         wrState;

  logic              readLoad, latchReq, latchWb, hitDone, missDone;
  logic [DATA_W-1:0] readLoadData;
  dirOp_t            nextOp;

  logic [ADDR_W-1:0] curAddr, wbAddr;
  logic [DATA_W-1:0] curData, wbData;
  logic              curWrite;
  dirOp_t            curOp;

  assign reqIdx   = addressP[IDX_W-1:0];
  assign reqTag   = addressP[ADDR_W-1:IDX_W];
  assign lineHit  = (rdState != MSI_I) && (rdTag == reqTag);
  assign invMatch = (invState != MSI_I) && (invTag == invAddr[ADDR_W-1:IDX_W]);
  assign invClr   = invValid && invMatch;
  assign dbgState = state;

  cache_line_array #(.LINES(LINES)) lines (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (wrEn),
    .wrIdx    (wrIdx),
    .wrTag    (wrTag),
    .wrData   (wrData),
    .wrState  (wrState),
    .rdIdx    (reqIdx),
    .rdTag    (rdTag),
    .rdData   (rdData),
    .rdState  (rdState),
    .invIdx   (invAddr[IDX_W-1:0]),
    .invClr   (invClr),
    .invTag   (invTag),
    .invData  (invLineData),
    .invState (invState)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state, stall, line writes and directory request fields
  always_comb begin
    nextState    = state;
    stallP       = 1'b0;
    wrEn         = 1'b0;
    wrIdx        = curAddr[IDX_W-1:0];
    wrTag        = curAddr[ADDR_W-1:IDX_W];
    wrData       = curData;
    wrState      = MSI_I;
    readLoad     = 1'b0;
    readLoadData = '0;
    latchReq     = 1'b0;
    latchWb      = 1'b0;
    nextOp       = OP_RD_MISS;
    hitDone      = 1'b0;
    missDone     = 1'b0;
    dirReqValid  = 1'b0;
    dirReqOp     = OP_RD_MISS;
    dirReqAddr   = '0;
    dirReqData   = '0;
    case (state)
      IDLE: begin
        if (reqValidP) begin
          if (invValid) begin
            // invalidation goes first; request re-evaluated next cycle
            stallP = 1'b1;
          end else if (lineHit && !operationP) begin
            readLoad     = 1'b1;
            readLoadData = rdData;
            hitDone      = 1'b1;
          end else if (lineHit && rdState == MSI_M) begin
            wrEn    = 1'b1;
            wrIdx   = reqIdx;
            wrTag   = reqTag;
            wrData  = dataP;
            wrState = MSI_M;
            hitDone = 1'b1;
          end else begin
            stallP   = 1'b1;
            latchReq = 1'b1;
            if (lineHit) begin
              nextOp    = OP_UPGRADE;
              nextState = MISS_REQ;
            end else begin
              nextOp = operationP ? OP_WR_MISS : OP_RD_MISS;
              if (rdState == MSI_M) begin
                latchWb   = 1'b1;
                nextState = WB_REQ;
              end else begin
                nextState = MISS_REQ;
              end
            end
          end
        end
      end
      WB_REQ: begin
        stallP      = 1'b1;
        dirReqValid = 1'b1;
        dirReqOp    = OP_WRITEBACK;
        dirReqAddr  = wbAddr;
        dirReqData  = wbData;
        if (dirReqReady) begin
          wrEn      = 1'b1;
          wrIdx     = wbAddr[IDX_W-1:0];
          wrTag     = wbAddr[ADDR_W-1:IDX_W];
          wrData    = wbData;
          wrState   = MSI_I;
          nextState = MISS_REQ;
        end
      end
      MISS_REQ: begin
        stallP      = 1'b1;
        dirReqValid = 1'b1;
        dirReqOp    = curOp;
        dirReqAddr  = curAddr;
        dirReqData  = curWrite ? curData : '0;
        if (dirReqReady) nextState = WAIT_RESP;
      end
      WAIT_RESP: begin
        stallP = 1'b1;
        if (dirRespValid) begin
          stallP    = 1'b0;
          wrEn      = 1'b1;
          wrData    = curWrite ? curData : dirRespData;
          wrState   = curWrite ? MSI_M : MSI_S;
          readLoad  = !curWrite;
          readLoadData = dirRespData;
          missDone  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Capture the request and victim when leaving IDLE so directory fields stay stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curAddr  <= '0;
      curData  <= '0;
      curWrite <= 1'b0;
      curOp    <= OP_RD_MISS;
      wbAddr   <= '0;
      wbData   <= '0;
    end else begin
      if (latchReq) begin
        curAddr  <= addressP;
        curData  <= dataP;
        curWrite <= operationP;
        curOp    <= nextOp;
      end
      if (latchWb) begin
        wbAddr <= {rdTag, reqIdx};
        wbData <= rdData;
      end
    end
  end

  // Registered processor read return and invalidation acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readValidP <= 1'b0;
      readDataP  <= '0;
      invAck     <= 1'b0;
      invData    <= '0;
      invDirty   <= 1'b0;
    end else begin
      readValidP <= readLoad;
      if (readLoad) readDataP <= readLoadData;
      invAck   <= invValid;
      invData  <= invClr ? invLineData : '0;
      invDirty <= invClr && (invState == MSI_M);
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hitDone && hitCount != 16'hFFFF)   hitCount  <= hitCount + 16'd1;
      if (missDone && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: stimulus pushes expected read returns,
// directory requests and invalidation acks into queues; a monitor pops and
// compares whenever the DUT presents one of those outputs.
module tb_cache_controller;
  import cache_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqValidP, operationP;
  logic [7:0] addressP, dataP;
  logic       stallP, readValidP;
  logic [7:0] readDataP;
  logic       dirReqValid, dirReqReady;
  logic [1:0] dirReqOp;
  logic [7:0] dirReqAddr, dirReqData;
  logic       dirRespValid;
  logic [7:0] dirRespData;
  logic       invValid, invAck, invDirty;
  logic [7:0] invAddr, invData;
  ctrlState_t dbgState;
`ifdef CACHE_STATS_EN
  logic [15:0] hitCount, missCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  resp_data = 8'h00;
  logic [7:0]  rd_exp_q[$];
  logic [17:0] dir_exp_q[$];
  logic [8:0]  inv_exp_q[$];

  cache_controller #(.LINES(4)) dut (
    .clk(clk), .reset(reset),
    .reqValidP(reqValidP), .operationP(operationP), .addressP(addressP), .dataP(dataP),
    .stallP(stallP), .readDataP(readDataP), .readValidP(readValidP),
    .dirReqValid(dirReqValid), .dirReqOp(dirReqOp), .dirReqAddr(dirReqAddr),
    .dirReqData(dirReqData), .dirReqReady(dirReqReady),
    .dirRespValid(dirRespValid), .dirRespData(dirRespData),
    .invValid(invValid), .invAddr(invAddr), .invAck(invAck), .invData(invData),
    .invDirty(invDirty), .dbgState(dbgState)
`ifdef CACHE_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] dir_ev(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  // monitor: pop and compare on every output event
  always @(negedge clk) begin
    if (!reset) begin
      if (readValidP) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", readValidP, 0);
        else check("rd_data", readDataP, rd_exp_q.pop_front());
      end
      if (dirReqValid && dirReqReady) begin
        if (dir_exp_q.size() == 0) check("dir_unexpected", dirReqValid, 0);
        else check("dir_req", {dirReqOp, dirReqAddr, dirReqData}, dir_exp_q.pop_front());
      end
      if (invAck) begin
        if (inv_exp_q.size() == 0) check("inv_unexpected", invAck, 0);
        else check("inv_ack", {invDirty, invData}, inv_exp_q.pop_front());
      end
    end
  end

  // directory responder: reply one cycle after each non-writeback handshake
  initial begin
    dirRespValid = 1'b0;
    dirRespData  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && dirReqValid && dirReqReady && dirReqOp != OP_WRITEBACK) begin
        @(posedge clk); #1;
        dirRespValid = 1'b1;
        dirRespData  = resp_data;
        @(posedge clk); #1;
        dirRespValid = 1'b0;
        dirRespData  = 8'h00;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stallP"}, stallP, 0);
    check({tag, "_readValidP"}, readValidP, 0);
    check({tag, "_readDataP"}, readDataP, 0);
    check({tag, "_dirReqValid"}, dirReqValid, 0);
    check({tag, "_dirReqOp"}, dirReqOp, 0);
    check({tag, "_dirReqAddr"}, dirReqAddr, 0);
    check({tag, "_dirReqData"}, dirReqData, 0);
    check({tag, "_invAck"}, invAck, 0);
    check({tag, "_invDirty"}, invDirty, 0);
    check({tag, "_invData"}, invData, 0);
    check({tag, "_state"}, dbgState, IDLE);
  endtask

  // issue one processor request and hold it until stallP drops
  task automatic proc_req(input logic wr, input logic [7:0] a, input logic [7:0] d, output int stalls);
    int n = 0;
    @(posedge clk); #1;
    reqValidP = 1'b1; operationP = wr; addressP = a; dataP = d;
    forever begin
      @(negedge clk);
      if (!stallP) break;
      n++;
      if (n > 60) begin
        check("req_timeout", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    reqValidP = 1'b0; operationP = 1'bx; addressP = 8'hxx; dataP = 8'hxx;
    stalls = n;
  endtask

  task automatic do_inv(input logic [7:0] a);
    @(posedge clk); #1;
    invValid = 1'b1; invAddr = a;
    @(posedge clk); #1;
    invValid = 1'b0; invAddr = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset = 1'b1;
    reqValidP = 1'b0; operationP = 1'b0; addressP = 8'h00; dataP = 8'h00;
    dirReqReady = 1'b1; invValid = 1'b0; invAddr = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // cold read miss, then hit with no traffic
    resp_data = 8'hAB;
    dir_exp_q.push_back(dir_ev(OP_RD_MISS, 8'h05, 8'h00));
    rd_exp_q.push_back(8'hAB);
    proc_req(1'b0, 8'h05, 8'h00, st);
    check("t1_miss_stalls", st, 2);
    rd_exp_q.push_back(8'hAB);
    proc_req(1'b0, 8'h05, 8'h00, st);
    check("t1_hit_stalls", st, 0);

    // write to S line -> UPGRADE, then reread
    resp_data = 8'h11;
    dir_exp_q.push_back(dir_ev(OP_UPGRADE, 8'h05, 8'h78));
    proc_req(1'b1, 8'h05, 8'h78, st);
    check("t2_upgrade_stalls", st, 2);
    rd_exp_q.push_back(8'h78);
    proc_req(1'b0, 8'h05, 8'h00, st);
    check("t2_hit_stalls", st, 0);

    // conflict miss on dirty victim -> WRITEBACK then RD_MISS
    resp_data = 8'h5A;
    dir_exp_q.push_back(dir_ev(OP_WRITEBACK, 8'h05, 8'h78));
    dir_exp_q.push_back(dir_ev(OP_RD_MISS, 8'h09, 8'h00));
    rd_exp_q.push_back(8'h5A);
    proc_req(1'b0, 8'h09, 8'h00, st);
    check("t3_wb_miss_stalls", st, 3);

    // write miss over clean victim, write hit in M, then invalidations
    resp_data = 8'h33;
    dir_exp_q.push_back(dir_ev(OP_WR_MISS, 8'h05, 8'h78));
    proc_req(1'b1, 8'h05, 8'h78, st);
    check("t4_wrmiss_stalls", st, 2);
    proc_req(1'b1, 8'h05, 8'h99, st);
    check("t4_wrhit_m_stalls", st, 0);
    inv_exp_q.push_back({1'b1, 8'h99});
    do_inv(8'h05);
    inv_exp_q.push_back({1'b0, 8'h00});
    do_inv(8'h06);
    inv_exp_q.push_back({1'b0, 8'h00});
    do_inv(8'h0D);
    resp_data = 8'hC4;
    dir_exp_q.push_back(dir_ev(OP_RD_MISS, 8'h05, 8'h00));
    rd_exp_q.push_back(8'hC4);
    proc_req(1'b0, 8'h05, 8'h00, st);
    check("t4_reread_miss_stalls", st, 2);

    // invalidation and read hit in the same cycle
    rd_exp_q.push_back(8'hC4);
    inv_exp_q.push_back({1'b0, 8'h00});
    @(posedge clk); #1;
    reqValidP = 1'b1; operationP = 1'b0; addressP = 8'h05;
    invValid = 1'b1; invAddr = 8'h0D;
    @(negedge clk);
    check("t5_stall_with_inv", stallP, 1);
    @(posedge clk); #1;
    invValid = 1'b0;
    @(negedge clk);
    check("t5_hit_next_cycle", stallP, 0);
    @(posedge clk); #1;
    reqValidP = 1'b0;

    // directory not ready: request held stable, then reset mid-wait
    dirReqReady = 1'b0;
    @(posedge clk); #1;
    reqValidP = 1'b1; operationP = 1'b0; addressP = 8'h0A;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_valid_held", dirReqValid, 1);
      check("t6_op_held", dirReqOp, OP_RD_MISS);
      check("t6_addr_held", dirReqAddr, 8'h0A);
      check("t6_stall_held", stallP, 1);
    end
    #2;
    reset = 1'b1;
    reqValidP = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    dirReqReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_req_after_reset", dirReqValid, 0);
    end

    // cache emptied by reset: previously cached address misses again
    resp_data = 8'h66;
    dir_exp_q.push_back(dir_ev(OP_RD_MISS, 8'h05, 8'h00));
    rd_exp_q.push_back(8'h66);
    proc_req(1'b0, 8'h05, 8'h00, st);
    check("t7_miss_after_reset", st, 2);

    repeat (3) @(posedge clk);
    check("rd_q_drained", rd_exp_q.size(), 0);
    check("dir_q_drained", dir_exp_q.size(), 0);
    check("inv_q_drained", inv_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
